// File: rtl/jk_pkg.sv
// Shared encodings for the JK excitation driver: command opcodes, FSM states,
// and the packed command record width.
package jk_pkg;

    typedef enum logic [1:0] {
        OP_HOLD   = 2'd0,
        OP_CLEAR  = 2'd1,
        OP_SET    = 2'd2,
        OP_TOGGLE = 2'd3
    } jk_op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_APPLY = 1'b1
    } jk_state_e;

    // Record layout is {op, rep, mask}.
    function automatic int cmd_rec_w(input int width, input int rep_w);
        return width + rep_w + 2;
    endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Command FIFO with full/empty/count. It updates on the falling edge so that it
// stays in step with the JK bank. Pointers wrap naturally because DEPTH is a power of 2.
module jk_cmd_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     Reset,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          do_push, do_pop;

    // Full blocks a push even when a pop lands on the same edge.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(negedge CLK or posedge Reset) begin
        if (Reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(negedge CLK) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/jk_cmd_driver.sv
// Plays buffered mask commands onto per-bit J/K lines for rep+1 periods and
// tracks the expected JK bank state in shadow_q.
module jk_cmd_driver
    import jk_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int REP_W = 4
) (
    input  logic                     CLK,
    input  logic                     Reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [WIDTH-1:0]         cmd_mask,
    input  logic [REP_W-1:0]         cmd_rep,
    output logic [WIDTH-1:0]         J,
    output logic [WIDTH-1:0]         K,
    output logic [WIDTH-1:0]         shadow_q,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int CMD_W = cmd_rec_w(WIDTH, REP_W);

    logic [CMD_W-1:0] push_rec, head_rec;
    logic             full, empty, pop, finish;
    logic [1:0]       head_op;
    logic [REP_W-1:0] head_rep, rep_cnt;
    logic [WIDTH-1:0] head_mask, head_j, head_k;
    jk_state_e        state_q, state_d;

    assign push_rec  = {cmd_op, cmd_rep, cmd_mask};
    assign {head_op, head_rep, head_mask} = head_rec;
    assign cmd_ready = !full;
    assign busy      = (state_q == ST_APPLY);

    jk_cmd_fifo #(.W(CMD_W), .DEPTH(DEPTH)) u_fifo (
        .CLK   (CLK),
        .Reset (Reset),
        .push  (cmd_valid),
        .wdata (push_rec),
        .pop   (pop),
        .rdata (head_rec),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    always_comb begin
        head_j = '0;
        head_k = '0;
        case (jk_op_e'(head_op))
            OP_CLEAR:  head_k = head_mask;
            OP_SET:    head_j = head_mask;
            OP_TOGGLE: begin
                head_j = head_mask;
                head_k = head_mask;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        finish  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = ST_APPLY;
                end
            end
            ST_APPLY: begin
                // Last period ends here; chain the next command without a gap.
                if (rep_cnt == '0) begin
                    finish = 1'b1;
                    if (!empty) pop = 1'b1;
                    else        state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(negedge CLK or posedge Reset) begin
        if (Reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(negedge CLK or posedge Reset) begin
        if (Reset) begin
            rep_cnt  <= '0;
            J        <= '0;
            K        <= '0;
            shadow_q <= '0;
            done     <= 1'b0;
        end else begin
            done     <= finish;
            // JK next-state: Q+ = J&~Q | ~K&Q, using last period's excitation.
            shadow_q <= (J & ~shadow_q) | (~K & shadow_q);
            if (pop) begin
                rep_cnt <= head_rep;
                J       <= head_j;
                K       <= head_k;
            end else if (state_q == ST_APPLY && rep_cnt != '0) begin
                rep_cnt <= rep_cnt - REP_W'(1);
            end else if (state_d == ST_IDLE) begin
                J <= '0;
                K <= '0;
            end
        end
    end

endmodule

// File: tb/tb_jk_cmd_driver.sv
// Scoreboard bench: the stimulus side predicts each command's excitation and
// end state, and a posedge monitor checks them against the DUT.
module tb_jk_cmd_driver;
    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int REP_W = 4;

    logic                   CLK = 1'b0;
    logic                   Reset = 1'b1;
    logic                   cmd_valid = 1'b0;
    logic [1:0]             cmd_op = '0;
    logic [WIDTH-1:0]       cmd_mask = '0;
    logic [REP_W-1:0]       cmd_rep = '0;
    logic                   cmd_ready, busy, done;
    logic [WIDTH-1:0]       J, K, shadow_q;
    logic [$clog2(DEPTH):0] fifo_count;

    typedef struct {
        logic [WIDTH-1:0] j;
        logic [WIDTH-1:0] k;
        logic [WIDTH-1:0] q;
        int               periods;
        longint           t_push;
    } exp_t;

    exp_t             sb[$];
    logic [WIDTH-1:0] model_q = '0;
    int               checks = 0, errors = 0, cur_periods = 0;
    bit               mon_en = 1'b0, saw_full = 1'b0;

    jk_cmd_driver #(.WIDTH(WIDTH), .DEPTH(DEPTH), .REP_W(REP_W)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_mask   (cmd_mask),
        .cmd_rep    (cmd_rep),
        .J          (J),
        .K          (K),
        .shadow_q   (shadow_q),
        .busy       (busy),
        .done       (done),
        .fifo_count (fifo_count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the opcode's J/K table, and the bank state after rep+1 applications.
    task automatic predict(input logic [1:0] op, input logic [WIDTH-1:0] m,
                           input logic [REP_W-1:0] rep, output exp_t e);
        e.periods = int'(rep) + 1;
        e.j = (op == 2'd2 || op == 2'd3) ? m : '0;
        e.k = (op == 2'd1 || op == 2'd3) ? m : '0;
        for (int n = 0; n < e.periods; n++) begin
            case (op)
                2'd1:    model_q = model_q & ~m;
                2'd2:    model_q = model_q | m;
                2'd3:    model_q = model_q ^ m;
                default: ;
            endcase
        end
        e.q = model_q;
        e.t_push = $time;
    endtask

    task automatic push(input logic [1:0] op, input logic [WIDTH-1:0] m, input logic [REP_W-1:0] rep);
        bit   acc;
        exp_t e;
        acc = 1'b0;
        @(posedge CLK); #1;
        cmd_valid = 1'b1; cmd_op = op; cmd_mask = m; cmd_rep = rep;
        for (int t = 0; t < 300 && !acc; t++) begin
            acc = cmd_ready;
            @(negedge CLK);
            if (acc) begin
                predict(op, m, rep, e);
                sb.push_back(e);
            end else begin
                @(posedge CLK); #1;
            end
        end
        if (!acc) chk("push_timeout", 32'd0, 32'd1);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 2000 && !ok; t++) begin
            @(posedge CLK); #1;
            ok = (sb.size() == 0) && !busy;
        end
        if (!ok) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        @(posedge CLK); #2;
        Reset = 1'b1; cmd_valid = 1'b0;
        #1;
        chk("rst_J", J, 0);
        chk("rst_K", K, 0);
        chk("rst_shadow", shadow_q, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", cmd_ready, 1);
        sb.delete();
        model_q = '0;
        cur_periods = 0;
        @(posedge CLK); #2;
        Reset = 1'b0;
    endtask

    always @(posedge CLK) begin : monitor
        exp_t e;
        int   ec;
        if (mon_en && !Reset) begin
            if (done) begin
                if (sb.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
                else begin
                    e = sb.pop_front();
                    chk("periods", cur_periods, e.periods);
                    chk("shadow_at_done", shadow_q, e.q);
                end
                cur_periods = 0;
            end
            if (busy) begin
                if (sb.size() == 0) chk("busy_unexpected", 32'd1, 32'd0);
                else begin
                    chk("J", J, sb[0].j);
                    chk("K", K, sb[0].k);
                    cur_periods++;
                end
            end else begin
                chk("J_idle", J, 0);
                chk("K_idle", K, 0);
                // Idle with work queued is only allowed right after a push into an empty FIFO.
                if (sb.size() > 0) chk("idle_gap", 32'($time - sb[0].t_push), 32'd5);
            end
            ec = sb.size() - (busy ? 1 : 0);
            chk("fifo_count", fifo_count, ec);
            chk("cmd_ready", cmd_ready, ec < DEPTH);
            if (!cmd_ready) saw_full = 1'b1;
        end
    end

    initial begin
        #3;
        chk("por_J", J, 0);
        chk("por_K", K, 0);
        chk("por_shadow", shadow_q, 0);
        chk("por_busy", busy, 0);
        chk("por_ready", cmd_ready, 1);
        @(posedge CLK); #2;
        Reset = 1'b0;
        mon_en = 1'b1;

        push(2'd2, 4'b1010, 4'd0);
        wait_idle();
        chk("set_shadow", shadow_q, 4'b1010);

        push(2'd3, 4'b1111, 4'd2);
        wait_idle();
        chk("toggle_shadow", shadow_q, 4'b0101);

        saw_full = 1'b0;
        push(2'd2, 4'b0011, 4'd3);
        push(2'd3, 4'b0110, 4'd3);
        push(2'd1, 4'b0001, 4'd3);
        push(2'd0, 4'b1111, 4'd3);
        push(2'd3, 4'b1000, 4'd3);
        wait_idle();
        chk("full_seen", saw_full, 1);

        push(2'd2, 4'b1111, 4'd0);
        push(2'd1, 4'b0011, 4'd15);
        wait_idle();
        chk("clear_rep15_shadow", shadow_q, 4'b1100);

        push(2'd0, 4'b1111, 4'd1);
        wait_idle();
        chk("hold_shadow", shadow_q, 4'b1100);

        push(2'd3, 4'b0110, 4'd5);
        push(2'd2, 4'b0001, 4'd0);
        push(2'd1, 4'b0001, 4'd0);
        do_reset();
        push(2'd2, 4'b0101, 4'd0);
        wait_idle();
        chk("post_reset_shadow", shadow_q, 4'b0101);

        for (int i = 0; i < 300; i++) begin
            push(2'($urandom_range(0, 3)), WIDTH'($urandom), REP_W'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 12)) @(posedge CLK);
            if ($urandom_range(0, 59) == 0) do_reset();
        end
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
